// File: rtl/pq_batch_sorter.sv
// pq_batch_sorter: batch front-end for a pq_if priority-queue device.
// Loads a batch of kv items from a valid/ready input stream into the PQ, then
// drains the PQ onto a valid/ready output stream so each batch leaves in PQ
// priority order.
//
// Parameters:
//   MAX_BATCH  maximum items per batch (must not exceed PQ capacity)
//   CW         occupancy counter width
//   KV_W       width of a packed kv item
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   s_kv/s_valid/s_last/s_ready   input item stream
//   m_kv/m_valid/m_last/m_ready   sorted output stream (registered)
//   pq_kvi/pq_enq/pq_deq          requests to the PQ device
//   pq_full/pq_busy/pq_empty/pq_kvo  status and head item from the PQ device
//   batch_done        one-cycle pulse after the final output handshake
//   ovf               sticky: a batch was cut short by pq_full
module pq_batch_sorter #(
  parameter int unsigned MAX_BATCH = 16,
  parameter int unsigned CW        = $clog2(MAX_BATCH + 1),
  parameter int unsigned KV_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [KV_W-1:0] s_kv,
  input  logic            s_valid,
  input  logic            s_last,
  output logic            s_ready,
  output logic [KV_W-1:0] m_kv,
  output logic            m_valid,
  output logic            m_last,
  input  logic            m_ready,
  output logic [KV_W-1:0] pq_kvi,
  output logic            pq_enq,
  output logic            pq_deq,
  input  logic            pq_full,
  input  logic            pq_busy,
  input  logic            pq_empty,
  input  logic [KV_W-1:0] pq_kvo,
  output logic            batch_done,
  output logic            ovf
);

  localparam logic [0:0]    ST_LOAD  = 1'b0;
  localparam logic [0:0]    ST_DRAIN = 1'b1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BATCH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KV_W-1:0] m_kv_q, m_kv_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic            batch_done_q, batch_done_d;
  logic            ovf_q, ovf_d;
  // Low while in reset; keeps s_ready deasserted until the first edge after release.
  logic            live_q;

  logic            s_ready_c;
  logic            enq_fire_c;
  logic            deq_fire_c;
  logic            obuf_free_c;
  logic            final_hs_c;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_LOAD;
      cnt_q        <= '0;
      m_kv_q       <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      batch_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      m_kv_q       <= m_kv_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      batch_done_q <= batch_done_d;
      ovf_q        <= ovf_d;
      live_q       <= 1'b1;
    end
  end

  // Next-state, PQ request and output-buffer logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    m_kv_d       = m_kv_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    batch_done_d = 1'b0;
    ovf_d        = ovf_q;
    s_ready_c    = 1'b0;
    enq_fire_c   = 1'b0;
    deq_fire_c   = 1'b0;
    obuf_free_c  = !m_valid_q || m_ready;
    final_hs_c   = m_valid_q && m_ready && m_last_q;

    case (state_q)
      ST_LOAD: begin
        s_ready_c  = live_q && !pq_full && !pq_busy;
        enq_fire_c = s_valid && s_ready_c;
        if (enq_fire_c) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          // cnt_q < MAX_BATCH here, so this compare cannot wrap.
          if (s_last || (cnt_q >= (CNT_MAX - CNT_ONE))) begin
            state_d = ST_DRAIN;
          end
        end else if (pq_full && (cnt_q != '0)) begin
          // PQ filled before the batch closed: drain what we have.
          state_d = ST_DRAIN;
          ovf_d   = 1'b1;
        end
      end

      ST_DRAIN: begin
        deq_fire_c = obuf_free_c && (cnt_q != '0) && !pq_empty && !pq_busy;
        if (deq_fire_c) begin
          m_kv_d    = pq_kvo;
          m_valid_d = 1'b1;
          m_last_d  = (cnt_q == CNT_ONE);
          cnt_d     = cnt_q - CNT_ONE;
        end else if (final_hs_c) begin
          m_valid_d    = 1'b0;
          m_last_d     = 1'b0;
          batch_done_d = 1'b1;
          cnt_d        = '0;
          state_d      = ST_LOAD;
        end else if (m_valid_q && m_ready) begin
          // Item consumed but the PQ cannot supply the next one yet.
          m_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign s_ready    = s_ready_c;
  assign pq_enq     = enq_fire_c;
  assign pq_deq     = deq_fire_c;
  assign pq_kvi     = s_kv;
  assign m_kv       = m_kv_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign batch_done = batch_done_q;
  assign ovf        = ovf_q;

endmodule

// File: doc/pq_batch_sorter.md
# pq_batch_sorter

Initiator-side client of the `pq_if` priority-queue protocol: it drives the `enq`/`deq`/`kvi` side and consumes `full`/`busy`/`empty`/`kvo` of any PQ device (`heap_pq`, `sr_pq`, …). It accepts a batch of `kv_t` items on a valid/ready input stream and loads them into the PQ. It then drains the PQ onto a valid/ready output stream, so each batch leaves in PQ priority order. It sits between a stream source and a PQ device and is the reusable front-end for sort benchmarks on the HWPQ study.

## Interface
- `MAX_BATCH`, default 16: maximum items per batch; must be ≤ PQ capacity.
- `CW`, default `$clog2(MAX_BATCH+1)`: width of the occupancy counter.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_kv`  in  kv_t  input item.
- `s_valid`  in  1  input item valid.
- `s_last`  in  1  marks final item of the batch (qualified by `s_valid`).
- `s_ready`  out  1  block accepts `s_kv` this cycle.
- `m_kv`  out  kv_t  output item, in PQ order.
- `m_valid`  out  1  `m_kv` valid.
- `m_last`  out  1  `m_kv` is the final item of the batch.
- `m_ready`  in  1  downstream accepts `m_kv`.
- `pq_kvi`  out  kv_t  to PQ `kvi`; combinational copy of `s_kv`.
- `pq_enq`  out  1  to PQ `enq`.
- `pq_deq`  out  1  to PQ `deq`.
- `pq_full`, `pq_busy`, `pq_empty`  in  1  from PQ.
- `pq_kvo`  in  kv_t  from PQ `kvo`: the head item, valid when `!pq_empty && !pq_busy`.
- `batch_done`  out  1  one-cycle pulse when the last item of a batch is accepted downstream.
- `ovf`  out  1  sticky: batch truncated because `pq_full` was seen during LOAD.

## Operation
- PQ protocol (`pq_if`):
  - An enqueue is performed when `pq_enq && !pq_full && !pq_busy`.
  - A dequeue removes the current `pq_kvo` when `pq_deq && !pq_empty && !pq_busy`.
  - The block never asserts `pq_enq` and `pq_deq` in the same cycle.
- State machine with states LOAD and DRAIN. Reset enters LOAD.
- LOAD:
  - `s_ready = !pq_full && !pq_busy`.
  - `pq_enq = s_valid && s_ready`, and `cnt` increments on each enqueue.
  - Transition to DRAIN on the enqueue that carries `s_last`, or that makes `cnt == MAX_BATCH`.
  - If `pq_full` is seen with `cnt > 0` and no last item has been accepted, transition to DRAIN and set `ovf`.
- DRAIN:
  - `s_ready = 0`.
  - One-entry output register `obuf`; `obuf` is free if `!m_valid || m_ready`.
  - When `obuf` is free, `cnt > 0`, `!pq_empty` and `!pq_busy`: assert `pq_deq`, capture `pq_kvo` into `obuf`, set `m_valid`, decrement `cnt`, and set `m_last = (cnt == 1)`.
  - On the `m_valid && m_ready && m_last` handshake: clear `m_valid`, pulse `batch_done`, clear `cnt`, return to LOAD.
- Width rules: `cnt` is `CW` bits, saturates at 0 and `MAX_BATCH`, and never wraps.
- Reset mid-operation: all state clears immediately. PQ contents are not flushed by this block; the top level resets the PQ on the same reset.

## Timing
- Reset values: `s_ready` 0 (asserted from the first cycle after deassert if the PQ is not full or busy), `m_valid` 0, `m_last` 0, `pq_enq` 0, `pq_deq` 0, `m_kv` 0, `batch_done` 0, `ovf` 0, `cnt` 0.
- Input throughput: one item per cycle whenever the PQ is not busy. `pq_enq` is combinational from `s_valid`.
- The first `m_valid` appears at the earliest 1 cycle after the LOAD→DRAIN transition, plus any `pq_busy` cycles.
- Output throughput: one item per cycle if `m_ready` is held high and the PQ does not raise `pq_busy` after a dequeue.
- `m_kv`, `m_valid` and `m_last` are registered. They hold stable while `m_valid && !m_ready`.
- `batch_done` is asserted in the cycle after the final handshake, and `s_ready` may rise in that same cycle.
- `pq_busy` stalls both phases without loss. `s_ready` and `pq_deq` stay low for as long as `pq_busy` is high.

## Test plan
- Basic sort: send keys 5,1,4,2,3 with `s_last` on 3, `m_ready`=1 → `m_kv` keys 1,2,3,4,5 (heap_pq order), `m_last` only on 5, one `batch_done` pulse, `ovf`=0.
- MAX_BATCH limit: `MAX_BATCH`=4, send 6 items with no `s_last` → the first 4 drain sorted with `m_last` on the 4th; `s_ready`=0 during DRAIN; items 5–6 form the next batch.
- Output backpressure: batch of 3 with `m_ready` toggling 1,0,0,1,… → `m_kv` holds while stalled, no item is lost or duplicated, and `pq_deq` is never asserted while `obuf` is occupied.
- Single item: one item with `s_last`, key 7 → `m_valid` with key 7 and `m_last`=1, `batch_done` pulse, back to LOAD.
- Overflow: PQ capacity 4 and `MAX_BATCH`=8, send 6 items → 4 enqueued, `pq_full` seen, `ovf`=1 sticky, 4 sorted outputs with `m_last` on the 4th.
- Reset mid-DRAIN: assert `rst`=0 after 2 of 5 outputs → `m_valid`, `cnt` and `ovf` clear at once; after release `s_ready`=1 once the PQ reports not busy.
